// File: rtl/bs_gnrtr_n_rbtr.sv
// bs_gnrtr_n_rbtr: per-bus round-robin arbiter that pops one device FIFO head and routes it to the other devices
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   pndng  : [bus][dev] packet waiting at the device FIFO head
//   pop    : [bus][dev] one-cycle strobe, device drops its FIFO head
//   D_pop  : [bus][dev] FIFO head packet of each device
//   push   : [bus][dev] one-cycle strobe, device accepts D_push
//   D_push : [bus][dev] last delivered packet, shared by all devices of a bus
module bs_gnrtr_n_rbtr #(
  parameter int bits = 1,
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0]              pop,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push
);
  localparam int PW = drvrs > 1 ? $clog2(drvrs) : 1;
  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;
  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, sel;
    logic [pckg_sz-1:0] pkt_q, pkt_d;
    logic [drvrs-1:0] pop_q, pop_d, push_q, push_d;
    logic [7:0] id;
    logic found;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        state_q <= IDLE;
        ptr_q   <= '0;
        gnt_q   <= '0;
        pkt_q   <= '0;
        pop_q   <= '0;
        push_q  <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        gnt_q   <= gnt_d;
        pkt_q   <= pkt_d;
        pop_q   <= pop_d;
        push_q  <= push_d;
      end
    // scanning downward leaves the first requester at or above the pointer in sel
    always_comb begin
      int idx;
      found = 1'b0;
      sel = ptr_q;
      for (int i = drvrs - 1; i >= 0; i--) begin
        idx = (int'(ptr_q) + i) % drvrs;
        if (pndng[b][idx]) begin
          found = 1'b1;
          sel = PW'(idx);
        end
      end
    end
    always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      gnt_d = gnt_q;
      pkt_d = pkt_q;
      unique case (state_q)
        IDLE: if (found) begin
          gnt_d = sel;
          state_d = POP;
        end
        POP: if (pndng[b][gnt_q]) begin
          pkt_d = D_pop[b][gnt_q];
          ptr_d = int'(gnt_q) == drvrs - 1 ? '0 : gnt_q + 1'b1;
          state_d = PUSH;
        end else state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    assign id = pkt_d[pckg_sz-1 -: 8];
    always_comb begin
      pop_d = '0;
      push_d = '0;
      for (int j = 0; j < drvrs; j++) begin
        pop_d[j] = state_d == POP && j == int'(gnt_d);
        push_d[j] = state_d == PUSH && (id == broadcast ? j != int'(gnt_q) : int'(id) == j);
      end
    end
    // a device that withdraws its request mid-pop never sees the strobe
    assign pop[b] = pop_q & pndng[b];
    assign push[b] = push_q;
    assign D_push[b] = {drvrs{pkt_q}};
  end
endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// tb_bs_gnrtr_n_rbtr: directed and random checks of the bus arbiter against a schedule-based model
module tb_bs_gnrtr_n_rbtr;
  localparam int B = 2, D = 4, W = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [B-1:0][D-1:0] pndng = '0, push, pop;
  logic [B-1:0][D-1:0][W-1:0] D_pop = '0, D_push;
  int total = 0, bad = 0;
  bs_gnrtr_n_rbtr #(.bits(B), .drvrs(D), .pckg_sz(W), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .push(push), .pop(pop), .D_pop(D_pop), .D_push(D_push)
  );
  always #5 clk = ~clk;
  logic [W-1:0] q[B][D][$];
  int ptr[B], free_at[B], push_at[B], rm_at[B], rm_dev[B], e = 0;
  logic [D-1:0] exp_pop[B], exp_push[B], push_mask[B];
  logic [W-1:0] exp_dp[B], push_pkt[B];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [D-1:0] route(logic [W-1:0] p, int g);
    logic [7:0] id = p[W-1 -: 8];
    logic [D-1:0] m = '0;
    for (int j = 0; j < D; j++) m[j] = id == 8'hFF ? j != g : int'(id) == j;
    return m;
  endfunction
  function automatic logic [W-1:0] rnd_pkt();
    int r = $urandom_range(0, 9);
    logic [7:0] id = r < 6 ? 8'(r % D) : r < 8 ? 8'hFF : 8'($urandom_range(D, 254));
    return {id, 8'($urandom)};
  endfunction
  task automatic drive();
    for (int b = 0; b < B; b++)
      for (int d = 0; d < D; d++) begin
        pndng[b][d] = q[b][d].size() != 0;
        D_pop[b][d] = q[b][d].size() != 0 ? q[b][d][0] : W'($urandom);
      end
  endtask
  task automatic model_reset();
    for (int b = 0; b < B; b++) begin
      for (int d = 0; d < D; d++) q[b][d].delete();
      ptr[b] = 0; free_at[b] = 0; push_at[b] = -1; rm_at[b] = -1;
      exp_pop[b] = '0; exp_push[b] = '0; exp_dp[b] = '0;
    end
  endtask
  // model: a free bus grants at the edge it sees a request, pushes one edge later, is free again three edges later
  task automatic step(bit inject);
    @(posedge clk);
    e++;
    for (int b = 0; b < B; b++) begin
      exp_pop[b] = '0;
      exp_push[b] = '0;
      if (rm_at[b] == e) void'(q[b][rm_dev[b]].pop_front());
      if (push_at[b] == e) begin
        exp_push[b] = push_mask[b];
        exp_dp[b] = push_pkt[b];
      end
      if (e >= free_at[b] && pndng[b] != '0) begin
        int g = -1;
        for (int k = 0; k < D; k++) if (g < 0 && pndng[b][(ptr[b] + k) % D]) g = (ptr[b] + k) % D;
        exp_pop[b][g] = 1'b1;
        push_pkt[b] = q[b][g][0];
        push_mask[b] = route(q[b][g][0], g);
        push_at[b] = e + 1;
        rm_at[b] = e + 1;
        rm_dev[b] = g;
        ptr[b] = (g + 1) % D;
        free_at[b] = e + 3;
      end
    end
    #1;
    for (int b = 0; b < B; b++) begin
      chk("pop", 64'(pop[b]), 64'(exp_pop[b]));
      chk("push", 64'(push[b]), 64'(exp_push[b]));
      for (int j = 0; j < D; j++) chk("dpush", 64'(D_push[b][j]), 64'(exp_dp[b]));
      if (inject && $urandom_range(0, 2) == 0) begin
        int d = $urandom_range(0, D - 1);
        if (q[b][d].size() < 3) q[b][d].push_back(rnd_pkt());
      end
    end
    drive();
  endtask
  // asserts reset at once, checks outputs stay cleared with all requests up, releases on a falling edge
  task automatic do_reset(int n);
    reset = 1'b0;
    model_reset();
    pndng = '1;
    #1;
    repeat (n) begin
      for (int b = 0; b < B; b++) begin
        chk("rst_pop", 64'(pop[b]), 64'd0);
        chk("rst_push", 64'(push[b]), 64'd0);
        chk("rst_dpush", 64'(D_push[b]), 64'd0);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    drive();
  endtask
  initial begin
    model_reset();
    do_reset(4);
    q[0][1].push_back(16'h02AB);
    drive();
    step(0);
    chk("uni_pop", 64'(pop[0]), 64'h2);
    step(0);
    chk("uni_push", 64'(push[0]), 64'h4);
    chk("uni_dpush", 64'(D_push[0][3]), 64'h02AB);
    step(0);
    chk("uni_done", 64'(push[0]), 64'h0);
    q[0][0].push_back(16'hFF55);
    drive();
    repeat (2) step(0);
    chk("bc_push", 64'(push[0]), 64'hE);
    step(0);
    do_reset(2);
    for (int d = 0; d < D; d++) begin
      q[0][d].push_back(16'h0100 | 16'(d));
      q[0][d].push_back(16'h0200 | 16'(d));
    end
    drive();
    for (int k = 0; k < 15; k++) begin
      step(0);
      if (k % 3 == 0) chk("rr_pop", 64'(pop[0]), 64'(4'b0001 << ((k / 3) % D)));
    end
    repeat (12) step(0);
    q[0][3].push_back(16'h0712);
    drive();
    step(0);
    chk("inv_pop", 64'(pop[0]), 64'h8);
    step(0);
    chk("inv_push", 64'(push[0]), 64'h0);
    step(0);
    q[0][0].push_back(16'h01CD);
    drive();
    step(0);
    chk("inv_next_pop", 64'(pop[0]), 64'h1);
    step(0);
    chk("inv_next_push", 64'(push[0]), 64'h2);
    step(0);
    q[0][2].push_back(16'h0011);
    drive();
    repeat (2) step(0);
    chk("mid_push", 64'(push[0]), 64'h1);
    do_reset(3);
    repeat (6) step(0);
    for (int k = 0; k < 800; k++) step(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
